// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus: instruction memory port, decode output stage and redirect request.
interface fetch_sequencer_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // master: the fetch sequencer
    modport master (
        output imem_addr,
        input  imem_data,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    // slave: memory plus decode plus branch unit
    modport slave (
        input  imem_addr,
        output imem_data,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, registers each fetched word into a
// one-entry valid/ready output stage, applies redirects with flush, and stops on
// a halt word, at the last memory word, or on an out-of-range redirect.
//
// state | meaning
// IDLE  | waiting for start; in-range redirects preload the PC
// FETCH | one fetch per cycle when the output stage is free
// HALT  | fetching stopped; held instruction may still drain; exit by reset
module fetch_sequencer #(
    parameter int          DEPTH     = 32,
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    fetch_sequencer_if.master   bus,
    output logic                halted,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);
    localparam logic [31:0] LAST_PC = 32'(DEPTH - 1);

    state_t      state;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        redirect_ok;
    logic        capture;

    // Memory is read combinationally at the current PC.
    assign bus.imem_addr   = pc;
    assign bus.instr       = instr;
    assign bus.instr_pc    = instr_pc;
    assign bus.instr_valid = instr_valid;

    // Redirect target legality and output-stage availability.
    always_comb begin
        redirect_ok = (bus.redirect_pc < DEPTH_W);
        capture     = !bus.redirect_valid && (!instr_valid || bus.instr_ready);
    end

    // Sequencer state, PC, output stage and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= 32'd0;
            instr_pc    <= 32'd0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            err         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.redirect_valid) begin
                        if (redirect_ok) begin
                            pc <= bus.redirect_pc;
                            if (start) state <= FETCH;
                        end else begin
                            state  <= HALT;
                            halted <= 1'b1;
                            err    <= 1'b1;
                        end
                    end else if (start) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.redirect_valid) begin
                        // Flush wins over a pending handshake.
                        instr_valid <= 1'b0;
                        if (redirect_ok) begin
                            pc <= bus.redirect_pc;
                        end else begin
                            state  <= HALT;
                            halted <= 1'b1;
                            err    <= 1'b1;
                        end
                    end else if (capture) begin
                        if (bus.imem_data != HALT_WORD) begin
                            instr       <= bus.imem_data;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            if (pc == LAST_PC) begin
                                state  <= HALT;
                                halted <= 1'b1;
                            end else begin
                                pc <= pc + 32'd1;
                            end
                        end else begin
                            instr_valid <= 1'b0;
                            state       <= HALT;
                            halted      <= 1'b1;
                        end
                    end
                end
                HALT: begin
                    if (instr_valid && bus.instr_ready) instr_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: per-cycle vector table plus a transfer scoreboard,
// and a hand-written reset sequence.
module tb_fetch_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic halted;
    logic err;
    logic [31:0] mem [32];

    fetch_sequencer_if bus ();

    fetch_sequencer #(.DEPTH(32), .RESET_PC(32'd0), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .bus    (bus),
        .halted (halted),
        .err    (err)
    );

    // Clock generation.
    always #5 clk = ~clk;

    assign bus.imem_data = (bus.imem_addr < 32'd32) ? mem[bus.imem_addr[4:0]] : 32'h0;

    typedef struct {
        logic        start;
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic [31:0] e_addr;
        logic        e_halted;
        logic        e_err;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } xfer_t;

    vec_t  vq[$];
    xfer_t sb[$];
    xfer_t mon_e;
    int    n_cmp = 0;
    int    n_bad = 0;

    localparam logic [31:0] A0 = 32'h2008_0001;
    localparam logic [31:0] A1 = 32'h2009_0002;
    localparam logic [31:0] A2 = 32'h0109_5020;
    localparam logic [31:0] HW = 32'hFFFF_FFFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic st, input logic rd, input logic rv,
                                input logic [31:0] rpc, input logic ev,
                                input logic [31:0] eipc, input logic [31:0] eins,
                                input logic [31:0] eaddr, input logic eh, input logic ee);
        vec_t v;
        v.start = st; v.ready = rd; v.rv = rv; v.rpc = rpc;
        v.e_valid = ev; v.e_ipc = eipc; v.e_instr = eins; v.e_addr = eaddr;
        v.e_halted = eh; v.e_err = ee;
        vq.push_back(v);
    endfunction

    function automatic void expect_xfer(input logic [31:0] pc, input logic [31:0] ins);
        xfer_t x;
        x.pc = pc; x.ins = ins;
        sb.push_back(x);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0;
        bus.instr_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic load_a();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[0] = A0; mem[1] = A1; mem[2] = A2; mem[3] = HW;
    endtask

    task automatic load_b();
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000_0000 + 32'(i);
    endtask

    // Inputs of vector i are applied, one edge passes, then outputs are compared.
    task automatic run_seg(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            start = vq[i].start;
            bus.instr_ready = vq[i].ready;
            bus.redirect_valid = vq[i].rv;
            bus.redirect_pc = vq[i].rpc;
            cyc();
            chk($sformatf("v%0d.valid", i), {31'd0, bus.instr_valid}, {31'd0, vq[i].e_valid});
            chk($sformatf("v%0d.addr", i), bus.imem_addr, vq[i].e_addr);
            chk($sformatf("v%0d.halted", i), {31'd0, halted}, {31'd0, vq[i].e_halted});
            chk($sformatf("v%0d.err", i), {31'd0, err}, {31'd0, vq[i].e_err});
            if (vq[i].e_valid) begin
                chk($sformatf("v%0d.instr_pc", i), bus.instr_pc, vq[i].e_ipc);
                chk($sformatf("v%0d.instr", i), bus.instr, vq[i].e_instr);
            end
        end
        idle_inputs();
        chk("scoreboard.drained", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Transfer monitor: a handshake seen mid-cycle completes at the next edge.
    always @(negedge clk) begin
        if (!reset && bus.instr_valid && bus.instr_ready) begin
            if (sb.size() == 0) begin
                chk("xfer.unexpected_pc", bus.instr_pc, 32'hDEAD_BEEF);
            end else begin
                mon_e = sb.pop_front();
                chk("xfer.pc", bus.instr_pc, mon_e.pc);
                chk("xfer.instr", bus.instr, mon_e.ins);
            end
        end
    end

    int s1, s2, s3, s4, s5, s6;

    initial begin
        idle_inputs();
        load_a();

        // Straight line through the halt word.
        s1 = vq.size();
        add(1,1,0,0,  0,0,0,0,  0,0);
        add(0,1,0,0,  1,0,A0,1, 0,0);
        add(0,1,0,0,  1,1,A1,2, 0,0);
        add(0,1,0,0,  1,2,A2,3, 0,0);
        add(0,1,0,0,  0,0,0,3,  1,0);
        add(0,1,0,0,  0,0,0,3,  1,0);
        // Backpressure for three cycles after first valid.
        s2 = vq.size();
        add(1,0,0,0,  0,0,0,0,  0,0);
        add(0,0,0,0,  1,0,A0,1, 0,0);
        add(0,0,0,0,  1,0,A0,1, 0,0);
        add(0,0,0,0,  1,0,A0,1, 0,0);
        add(0,0,0,0,  1,0,A0,1, 0,0);
        add(0,1,0,0,  1,1,A1,2, 0,0);
        add(0,1,0,0,  1,2,A2,3, 0,0);
        add(0,1,0,0,  0,0,0,3,  1,0);
        // Redirect to 10, then out-of-range redirect to 40; HALT ignores inputs.
        s3 = vq.size();
        add(1,1,0,0,  0,0,0,0,  0,0);
        add(0,1,0,0,  1,0,32'h1000_0000,1,  0,0);
        add(0,1,0,0,  1,1,32'h1000_0001,2,  0,0);
        add(0,1,1,10, 0,0,0,10, 0,0);
        add(0,1,0,0,  1,10,32'h1000_000A,11, 0,0);
        add(0,1,0,0,  1,11,32'h1000_000B,12, 0,0);
        add(0,1,1,40, 0,0,0,12, 1,1);
        add(1,1,1,5,  0,0,0,12, 1,1);
        // End of memory reached via IDLE preload to 29; last word drains in HALT.
        s4 = vq.size();
        add(0,0,1,29, 0,0,0,29, 0,0);
        add(1,1,0,0,  0,0,0,29, 0,0);
        add(0,1,0,0,  1,29,32'h1000_001D,30, 0,0);
        add(0,1,0,0,  1,30,32'h1000_001E,31, 0,0);
        add(0,1,0,0,  1,31,32'h1000_001F,31, 1,0);
        add(0,0,0,0,  1,31,32'h1000_001F,31, 1,0);
        add(0,1,0,0,  0,0,0,31, 1,0);
        add(0,1,0,0,  0,0,0,31, 1,0);
        // IDLE redirect boundaries: DEPTH-1 legal, DEPTH illegal.
        s5 = vq.size();
        add(0,0,1,31, 0,0,0,31, 0,0);
        add(0,0,1,32, 0,0,0,31, 1,1);
        add(1,0,0,0,  0,0,0,31, 1,1);
        s6 = vq.size();

        cyc();
        reset = 1'b0;
        chk("reset.valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("reset.addr", bus.imem_addr, 32'd0);
        chk("reset.instr", bus.instr, 32'd0);
        chk("reset.instr_pc", bus.instr_pc, 32'd0);
        chk("reset.halted", {31'd0, halted}, 32'd0);
        chk("reset.err", {31'd0, err}, 32'd0);

        expect_xfer(0, A0); expect_xfer(1, A1); expect_xfer(2, A2);
        run_seg(s1, s2);

        do_reset();
        expect_xfer(0, A0); expect_xfer(1, A1); expect_xfer(2, A2);
        run_seg(s2, s3);

        do_reset();
        load_b();
        expect_xfer(0, 32'h1000_0000); expect_xfer(1, 32'h1000_0001);
        expect_xfer(10, 32'h1000_000A); expect_xfer(11, 32'h1000_000B);
        run_seg(s3, s4);

        do_reset();
        expect_xfer(29, 32'h1000_001D); expect_xfer(30, 32'h1000_001E);
        expect_xfer(31, 32'h1000_001F);
        run_seg(s4, s5);

        do_reset();
        run_seg(s5, s6);

        // Reset while an instruction is held under backpressure.
        do_reset();
        chk("rst2.err_cleared", {31'd0, err}, 32'd0);
        load_a();
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        chk("rst2.held_valid", {31'd0, bus.instr_valid}, 32'd1);
        reset = 1'b1;
        cyc();
        chk("rst2.valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst2.addr", bus.imem_addr, 32'd0);
        chk("rst2.halted", {31'd0, halted}, 32'd0);
        chk("rst2.err", {31'd0, err}, 32'd0);
        chk("rst2.instr", bus.instr, 32'd0);
        reset = 1'b0;
        bus.instr_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk($sformatf("rst2.idle%0d.valid", k), {31'd0, bus.instr_valid}, 32'd0);
            chk($sformatf("rst2.idle%0d.addr", k), bus.imem_addr, 32'd0);
        end
        idle_inputs();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
